// File: rtl/fst_prefetch.sv
// fst_prefetch: decoupled instruction prefetch engine with a DEPTH-entry FIFO feeding decode
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   imem_req/imem_adr     read request and address to the 1-cycle-latency instruction memory
//   imem_dat              read data, valid one cycle after imem_req
//   out_valid/out_ready   head handshake toward decode
//   out_inst/out_pcinc    head instruction and its address plus one
//   redirect/redirect_adr flush and restart fetch at a new address
//   halt                  suppress new requests while high
//   count                 FIFO occupancy
module fst_prefetch #(
  parameter int DATA_W = 16,
  parameter int ADR_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADR_W-1:0]           imem_adr,
  input  logic [DATA_W-1:0]          imem_dat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_inst,
  output logic [ADR_W-1:0]           out_pcinc,
  input  logic                       redirect,
  input  logic [ADR_W-1:0]           redirect_adr,
  input  logic                       halt,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [ADR_W-1:0] fetch_pc_q, fetch_pc_d, tag_q, tag_d;
  logic inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [ADR_W-1:0] pcinc_q [DEPTH];
  logic push, pop;
  always_comb begin
    // the in-flight word already owns a slot, so a push can never land on a full FIFO
    imem_req = !reset && !halt && !redirect &&
               ((CW+1)'(count_q) + (CW+1)'(inflight_q) < (CW+1)'(DEPTH));
    imem_adr = fetch_pc_q;
    // a response arriving in a redirect or reset cycle belongs to the abandoned stream
    push = inflight_q && !redirect && !reset;
    out_valid = count_q != '0;
    pop = out_valid && out_ready;
    out_inst = inst_q[rd_ptr_q];
    out_pcinc = pcinc_q[rd_ptr_q];
    count = count_q;
    fetch_pc_d = redirect ? redirect_adr : imem_req ? fetch_pc_q + ADR_W'(1) : fetch_pc_q;
    inflight_d = imem_req;
    tag_d = imem_req ? fetch_pc_q : tag_q;
    wr_ptr_d = redirect ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = redirect ? '0 : rd_ptr_q + PW'(pop);
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= imem_dat;
      pcinc_q[wr_ptr_q] <= tag_q + ADR_W'(1);
    end
  end
endmodule

// File: tb/tb_fst_prefetch.sv
// tb_fst_prefetch: directed steps plus a request-driven scoreboard for fst_prefetch
module tb_fst_prefetch;
  logic clk = 1'b0;
  logic reset, out_ready, halt, redirect;
  logic [15:0] redirect_adr;
  logic imem_req, out_valid;
  logic [15:0] imem_adr, imem_dat, out_inst, out_pcinc;
  logic [2:0] count;
  logic imem_req2, out_valid2;
  logic [15:0] imem_adr2, imem_dat2, out_inst2, out_pcinc2;
  logic [2:0] count2;
  logic ready2 = 1'b1, zero = 1'b0;
  logic [15:0] zero16 = 16'h0000;
  int total = 0, bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] head;

  always #5 clk = ~clk;

  fst_prefetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_adr(imem_adr), .imem_dat(imem_dat),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pcinc(out_pcinc),
    .redirect(redirect), .redirect_adr(redirect_adr), .halt(halt), .count(count)
  );

  fst_prefetch #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_adr(imem_adr2), .imem_dat(imem_dat2),
    .out_valid(out_valid2), .out_ready(ready2), .out_inst(out_inst2), .out_pcinc(out_pcinc2),
    .redirect(zero), .redirect_adr(zero16), .halt(zero), .count(count2)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    imem_dat <= imem_req ? memf(imem_adr) : 16'hDEAD;
    imem_dat2 <= imem_req2 ? memf(imem_adr2) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic rdy, input logic hl, input logic rd, input logic [15:0] ra);
    @(posedge clk);
    #1;
    reset = rs;
    out_ready = rdy;
    halt = hl;
    redirect = rd;
    redirect_adr = ra;
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk("sb_expected_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        chk("sb_word", {out_inst, out_pcinc}, head);
      end
    end
    if (reset || redirect) exp_q.delete();
    if (imem_req) exp_q.push_back({memf(imem_adr), imem_adr + 16'd1});
    if (!reset) chk("no_full_push", 32'(dut.push && count == 3'd4), 32'd0);
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_adr = '0;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req2", 32'(imem_req2), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("a0_req", 32'(imem_req), 32'd1);
    chk("a0_adr", 32'(imem_adr), 32'h0000);
    chk("a0_valid", 32'(out_valid), 32'd0);
    chk("wrap_adr0", 32'(imem_adr2), 32'hFFFE);
    cyc(0, 1, 0, 0, 0);
    chk("a1_adr", 32'(imem_adr), 32'h0001);
    chk("a1_valid", 32'(out_valid), 32'd0);
    chk("wrap_adr1", 32'(imem_adr2), 32'hFFFF);
    cyc(0, 1, 0, 0, 0);
    chk("a2_valid", 32'(out_valid), 32'd1);
    chk("a2_inst", 32'(out_inst), 32'h1000);
    chk("a2_pcinc", 32'(out_pcinc), 32'h0001);
    chk("a2_adr", 32'(imem_adr), 32'h0002);
    chk("wrap_adr2", 32'(imem_adr2), 32'h0000);
    chk("wrap_inst0", 32'(out_inst2), 32'h0FFE);
    chk("wrap_pcinc0", 32'(out_pcinc2), 32'hFFFF);
    cyc(0, 1, 0, 0, 0);
    chk("a3_inst", 32'(out_inst), 32'h1001);
    chk("a3_pcinc", 32'(out_pcinc), 32'h0002);
    chk("wrap_inst1", 32'(out_inst2), 32'h0FFF);
    chk("wrap_pcinc1", 32'(out_pcinc2), 32'h0000);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("bp0_req", 32'(imem_req), 32'd1);
    chk("bp0_adr", 32'(imem_adr), 32'h0000);
    for (int i = 1; i < 10; i++) begin
      int c;
      cyc(0, 0, 0, 0, 0);
      c = (i - 1 > 4) ? 4 : i - 1;
      chk("bp_req", 32'(imem_req), 32'(i < 4));
      chk("bp_count", 32'(count), 32'(c));
      if (i >= 2) chk("bp_head", 32'(out_inst), 32'h1000);
    end
    cyc(0, 1, 0, 0, 0);
    chk("rel_req", 32'(imem_req), 32'd0);
    chk("rel_count", 32'(count), 32'd4);
    chk("rel_head", 32'(out_inst), 32'h1000);
    cyc(0, 1, 0, 0, 0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_adr", 32'(imem_adr), 32'h0004);
    chk("resume_count", 32'(count), 32'd3);
    repeat (6) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 16'h0040);
    chk("rd_count", 32'(count), 32'd2);
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("rd1_count", 32'(count), 32'd0);
    chk("rd1_valid", 32'(out_valid), 32'd0);
    chk("rd1_req", 32'(imem_req), 32'd1);
    chk("rd1_adr", 32'(imem_adr), 32'h0040);
    cyc(0, 1, 0, 0, 0);
    chk("rd2_adr", 32'(imem_adr), 32'h0041);
    chk("rd2_valid", 32'(out_valid), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("h0_valid", 32'(out_valid), 32'd1);
    chk("h0_inst", 32'(out_inst), 32'h1040);
    chk("h0_pcinc", 32'(out_pcinc), 32'h0041);
    chk("h0_count", 32'(count), 32'd1);
    chk("h0_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("h1_count", 32'(count), 32'd1);
    chk("h1_inst", 32'(out_inst), 32'h1041);
    chk("h1_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("h2_valid", 32'(out_valid), 32'd0);
    chk("h2_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("h3_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("hrel_req", 32'(imem_req), 32'd1);
    chk("hrel_adr", 32'(imem_adr), 32'h0042);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 16'h0080);
    chk("hrd_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("hrd_count", 32'(count), 32'd0);
    chk("hrd_req1", 32'(imem_req), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("hrd_resume_req", 32'(imem_req), 32'd1);
    chk("hrd_resume_adr", 32'(imem_adr), 32'h0080);
    repeat (5) cyc(0, 1, 0, 0, 0);
    begin
      int n = 0;
      cyc(0, 1, 1, 0, 0);
      while (count != 0 && n < 20) begin
        cyc(0, 1, 1, 0, 0);
        n++;
      end
      chk("drain_count", 32'(count), 32'd0);
      cyc(0, 1, 1, 0, 0);
      chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fst_prefetch.md
Name: fst_prefetch

Overview:
Parametrised instruction prefetch unit for the next-generation fst pipeline. It replaces the single-cycle pc/inst fetch with a decoupled fetch engine. The engine drives a synchronous instruction memory with fixed 1-cycle read latency and buffers fetched words in a DEPTH-entry FIFO. It hands {inst, pcinc} to decode with a valid/ready handshake, and supports branch redirect/flush and halt.

Parameters:
DATA_W, 16, instruction word width
ADR_W, 16, instruction address width; pc arithmetic is modulo 2^ADR_W
DEPTH, 4, FIFO entries; legal range 2..16, power of two; DEPTH>=3 is required for 1 inst/cycle throughput
RESET_PC, 0, fetch address loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory this cycle
imem_adr  out  ADR_W  read address; valid when imem_req=1
imem_dat  in  DATA_W  read data; valid exactly one cycle after imem_req
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head; stall when 0
out_inst  out  DATA_W  instruction at FIFO head
out_pcinc  out  ADR_W  address of head instruction plus 1, mod 2^ADR_W
redirect  in  1  taken branch/jump: flush and refetch
redirect_adr  in  ADR_W  new fetch address; sampled when redirect=1
halt  in  1  level: stop issuing new requests
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - fetch_pc=RESET_PC, FIFO empty, count=0, inflight=0, out_valid=0.
  - imem_req=0 during any cycle with reset=1.
  - A response to a request issued in the cycle before reset is discarded.
- State: fetch_pc, FIFO (rd/wr pointers, entries {inst, pcinc}), inflight bit with its address tag.
- Issue:
  - imem_req = !reset & !halt & !redirect & (count + inflight < DEPTH).
  - imem_adr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1 (wraps 2^ADR_W-1 -> 0), inflight <= 1, tag <= fetch_pc.
  - Otherwise inflight <= 0.
- Capture: in a cycle with inflight=1 and redirect=0, push {imem_dat, tag+1} at the end of that cycle.
- Latency: req in cycle N with adr A -> out_valid=1 in cycle N+2 with out_inst=mem[A], out_pcinc=A+1. There is no bypass.
- Output:
  - out_valid = (count != 0).
  - out_inst/out_pcinc = head entry; both hold stable while out_valid & !out_ready.
  - pop = out_valid & out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: the issue condition reserves space for the in-flight word, so a push into a full FIFO never occurs. Verification asserts this.
- Empty: out_valid=0; out_ready is ignored.
- Redirect (priority over issue and capture):
  - In the redirect cycle: FIFO cleared (count=0 next cycle), the in-flight response arriving that cycle is discarded, imem_req=0, fetch_pc <= redirect_adr.
  - Next cycle (if not halted): req with adr=redirect_adr.
  - A pop in the redirect cycle is legal and completes.
  - out_valid may be 1 in the redirect cycle (old contents).
- Halt:
  - No new requests while halt=1.
  - An in-flight response is still captured.
  - The FIFO still drains to decode.
  - Fetch resumes from the preserved fetch_pc the cycle halt drops.
- Redirect during halt: flush and fetch_pc update still occur.
- Throughput: with out_ready held at 1 and DEPTH>=3, one instruction per cycle in steady state.

Test Plan:
- Reset, then stream: mem[i]=0x1000+i, RESET_PC=0, out_ready=1 -> req adr 0,1,2... from cycle 1; out_inst 0x1000,0x1001,... from cycle 3, one per cycle; out_pcinc 1,2,3...
- Backpressure: out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_req=0 once count+inflight=4, head holds 0x1000. Release -> 0x1000..0x1003 in order with no loss or duplicate, and fetch resumes at adr 4.
- Redirect with in-flight: redirect=1, redirect_adr=0x0040 while inflight=1 and count=2 -> next cycle count=0 and the in-flight word is dropped; req adr 0x0040, first out_inst=mem[0x40] with out_pcinc=0x0041.
- Redirect with simultaneous pop: out_valid=1, out_ready=1, redirect=1 -> head popped, FIFO empty next cycle, no stale word ever appears afterward.
- Halt: halt=1 with one in-flight and count=1 -> both words delivered, no req; halt=0 -> req at the preserved fetch_pc.
- Wrap and mid-run reset: RESET_PC=0xFFFE -> adr 0xFFFE, 0xFFFF, 0x0000; out_pcinc 0xFFFF, 0x0000. Asserting reset mid-stream -> next cycle count=0, out_valid=0, and the pending response is never pushed.
